vision_bbox_overlay: RTL
========================

VISION_BBOX_OVERLAY -- requirements
Module: vision_bbox_overlay

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IMAGE_W, 640, pixels per line
- IMAGE_H, 480, lines per frame
- R_MIN, 8'd180, minimum red level for a hit
- G_MAX, 8'd90, maximum green level for a hit
- B_MAX, 8'd90, maximum blue level for a hit
- BOX_COLOR, 24'hFFFF00, overlay colour
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are (name, direction, width, meaning):
- clk, in, 1, sole clock
- reset_n, in, 1, async active-low reset
- sink_data, in, 24, Avalon-ST video pixel {R[23:16],G[15:8],B[7:0]}
- sink_valid, in, 1, sink beat valid
- sink_ready, out, 1, block accepts beat
- sink_startofpacket, in, 1, first beat of packet
- sink_endofpacket, in, 1, last beat of packet
- source_data, out, 24, output pixel
- source_valid, out, 1, output beat valid
- source_ready, in, 1, downstream accepts beat
- source_startofpacket, out, 1, first beat
- source_endofpacket, out, 1, last beat
- mode, in, 1, 1 = draw overlay, 0 = pass-through
- bbox_valid, out, 1, latched box is valid
- bbox_x_min, out, 11, latched box left column
- bbox_x_max, out, 11, latched box right column
- bbox_y_min, out, 11, latched box top row
- bbox_y_max, out, 11, latched box bottom row
- hit_count, out, 20, hits in the last completed frame

Function
REQ-003 The datapath SHALL be one registered pipeline stage: sink_ready = source_ready OR NOT source_valid; a beat is accepted when sink_valid AND sink_ready, and appears on source the next cycle with sop/eop copied.
REQ-004 Source outputs SHALL hold stable while source_valid=1 and source_ready=0.
REQ-005 FSM states SHALL be IDLE, CTRL and VIDEO.
REQ-006 In IDLE, an accepted sop beat with data[3:0]==0 SHALL go to VIDEO; any other sop beat SHALL go to CTRL; non-sop beats SHALL be passed unmodified and leave the state unchanged.
REQ-007 The header beat SHALL always pass unmodified.
REQ-008 CTRL SHALL pass beats unmodified and return to IDLE on an accepted eop.
REQ-009 In VIDEO, each accepted non-header beat is one pixel at column x, row y; x,y start at 0; x wraps IMAGE_W-1 -> 0 and increments y.
REQ-010 Pixels with y >= IMAGE_H SHALL pass unmodified and SHALL NOT be counted.
REQ-011 A pixel is a hit when R >= R_MIN, G <= G_MAX and B <= B_MAX; hits SHALL be evaluated on input pixels, never on overlaid ones.
REQ-012 Working min/max x/y and the hit counter (20-bit, saturating at 2^20-1) SHALL reset at each VIDEO header.
REQ-013 On an accepted eop in VIDEO the block SHALL latch the working box into the bbox_* outputs, set hit_count, set bbox_valid = (hits != 0), and return to IDLE; latched outputs update the cycle after eop acceptance.
REQ-014 If zero hits, bbox_x/y_* SHALL be latched as 0.
REQ-015 A sop arriving while in VIDEO or CTRL SHALL abort the current packet without latching and SHALL be decoded as a new header per REQ-006.
REQ-016 With mode=1 and bbox_valid=1, a counted pixel SHALL be replaced by BOX_COLOR when it lies on the box edge:
- (x==x_min or x==x_max) and y_min<=y<=y_max, or
- (y==y_min or y==y_max) and x_min<=x<=x_max.
The box used is the one latched from the previous frame.
REQ-017 mode SHALL be sampled per accepted beat, with no frame alignment.

Reset
REQ-018 While reset_n=0: FSM=IDLE, x=y=0, source_valid=0, source_data=0, source_sop=source_eop=0, bbox_valid=0, all bbox_* = 0, hit_count=0; sink_ready=1 after reset release.
REQ-019 Reset asserted mid-frame SHALL discard the frame; the first post-reset sop is decoded fresh.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Frame 640x480 black except a red (FF,00,00) 10x10 square at x=100..109, y=50..59 -> bbox=(100,109,50,59), hit_count=100, bbox_valid=1.
- Same frame again with mode=1 -> pixel (100,55) and (105,50) output FFFF00; (105,55) output unchanged FF0000; with mode=0, output == input.
- Control packet (header data[3:0]=0xF, 4 beats) between frames -> passes unmodified; bbox unchanged.
- source_ready toggled randomly 50% -> no beat lost/duplicated; outputs stable during stall; stats identical to no-stall run.
- All-black frame -> bbox_valid=0, hit_count=0, bbox_* =0; next frame with mode=1 unchanged.
- sop injected at pixel 1000 of a frame, then full frame -> first frame not latched; second latches correctly; reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/vision_bbox_overlay.sv
// ---------------------------------------------------------------------------
// vision_bbox_overlay
//
// Purpose
//   Avalon-ST video filter with a single registered pipeline stage. It watches
//   video packets for "red" pixels and tracks their bounding box and count.
//   At the end of each video frame the box and count are latched to the
//   bbox_* / hit_count outputs. When mode=1 and a valid box is latched, the
//   rectangle outline of that box (from the previous frame) is painted into
//   the outgoing pixels in BOX_COLOR. Control packets pass through untouched.
//
// Ports
//   clk, reset_n          sole clock, asynchronous active-low reset
//   sink_*                Avalon-ST input (24-bit RGB {R,G,B}, sop/eop)
//   source_*              Avalon-ST output, one register stage behind sink
//   mode                  1 = draw box outline, 0 = pass-through
//   bbox_valid            latched box holds at least one hit
//   bbox_x/y_min/max      latched box edges (zero when no hits)
//   hit_count             hits in the last completed frame (saturating)
// ---------------------------------------------------------------------------
module vision_bbox_overlay #(
  parameter int unsigned  IMAGE_W   = 640,
  parameter int unsigned  IMAGE_H   = 480,
  parameter logic [7:0]   R_MIN     = 8'd180,
  parameter logic [7:0]   G_MAX     = 8'd90,
  parameter logic [7:0]   B_MAX     = 8'd90,
  parameter logic [23:0]  BOX_COLOR = 24'hFFFF00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_startofpacket,
  input  logic        sink_endofpacket,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_startofpacket,
  output logic        source_endofpacket,
  input  logic        mode,
  output logic        bbox_valid,
  output logic [10:0] bbox_x_min,
  output logic [10:0] bbox_x_max,
  output logic [10:0] bbox_y_min,
  output logic [10:0] bbox_y_max,
  output logic [19:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CTRL  = 2'd1,
    VIDEO = 2'd2
  } state_t;

  localparam logic [10:0] X_LAST  = 11'(IMAGE_W - 1);
  localparam logic [11:0] Y_END   = 12'(IMAGE_H);
  localparam logic [19:0] HIT_SAT = 20'hFFFFF;

  state_t      state_q, state_d;

  // Output pipeline register
  logic [23:0] src_data_q, src_data_d;
  logic        src_valid_q, src_valid_d;
  logic        src_sop_q, src_sop_d;
  logic        src_eop_q, src_eop_d;

  // Pixel position inside the current video packet
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;

  // Working statistics of the frame in progress
  logic [10:0] wx_min_q, wx_min_d;
  logic [10:0] wx_max_q, wx_max_d;
  logic [10:0] wy_min_q, wy_min_d;
  logic [10:0] wy_max_q, wy_max_d;
  logic [19:0] whits_q, whits_d;

  // Latched results of the last completed frame
  logic        bvalid_q, bvalid_d;
  logic [10:0] bx_min_q, bx_min_d;
  logic [10:0] bx_max_q, bx_max_d;
  logic [10:0] by_min_q, by_min_d;
  logic [10:0] by_max_q, by_max_d;
  logic [19:0] bhits_q, bhits_d;

  logic        accept;
  logic        header;
  logic        video_pix;
  logic        counted;
  logic        hit;
  logic        on_edge;
  logic        overlay;

  assign sink_ready = source_ready | ~src_valid_q;
  assign accept     = sink_valid & sink_ready;
  assign header     = accept & sink_startofpacket;
  assign video_pix  = accept & ~sink_startofpacket & (state_q == VIDEO);
  // Rows past the nominal frame height are forwarded but ignored.
  assign counted    = video_pix & ({1'b0, y_q} < Y_END);
  // Hit test always looks at the incoming pixel, never the painted one.
  assign hit        = counted
                    & (sink_data[23:16] >= R_MIN)
                    & (sink_data[15:8]  <= G_MAX)
                    & (sink_data[7:0]   <= B_MAX);
  assign on_edge    = (((x_q == bx_min_q) || (x_q == bx_max_q))
                        && (y_q >= by_min_q) && (y_q <= by_max_q))
                   || (((y_q == by_min_q) || (y_q == by_max_q))
                        && (x_q >= bx_min_q) && (x_q <= bx_max_q));
  assign overlay    = counted & mode & bvalid_q & on_edge;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state. Any sop is decoded as a fresh header regardless of the
  // current state, which is also how an unfinished packet gets aborted.
  // A header that is also its own eop carries no payload, so go back to IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (header) begin
      if (sink_endofpacket) begin
        state_d = IDLE;
      end else if (sink_data[3:0] == 4'h0) begin
        state_d = VIDEO;
      end else begin
        state_d = CTRL;
      end
    end else if (accept && (state_q != IDLE) && sink_endofpacket) begin
      state_d = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    src_data_d  = src_data_q;
    src_valid_d = src_valid_q;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    x_d         = x_q;
    y_d         = y_q;
    wx_min_d    = wx_min_q;
    wx_max_d    = wx_max_q;
    wy_min_d    = wy_min_q;
    wy_max_d    = wy_max_q;
    whits_d     = whits_q;
    bvalid_d    = bvalid_q;
    bx_min_d    = bx_min_q;
    bx_max_d    = bx_max_q;
    by_min_d    = by_min_q;
    by_max_d    = by_max_q;
    bhits_d     = bhits_q;

    if (accept) begin
      src_valid_d = 1'b1;
      src_data_d  = overlay ? BOX_COLOR : sink_data;
      src_sop_d   = sink_startofpacket;
      src_eop_d   = sink_endofpacket;
    end else if (source_ready) begin
      src_valid_d = 1'b0;
    end

    // Clearing on every header is harmless for control packets: the next
    // video header clears again before anything is accumulated.
    if (header) begin
      x_d      = '0;
      y_d      = '0;
      wx_min_d = '1;
      wx_max_d = '0;
      wy_min_d = '1;
      wy_max_d = '0;
      whits_d  = '0;
    end else if (video_pix) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        // Hold y at its maximum so an overlong packet cannot wrap back
        // into the counted region.
        if (y_q != 11'h7FF) begin
          y_d = y_q + 11'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end

      if (hit) begin
        if (x_q < wx_min_q) wx_min_d = x_q;
        if (x_q > wx_max_q) wx_max_d = x_q;
        if (y_q < wy_min_q) wy_min_d = y_q;
        if (y_q > wy_max_q) wy_max_d = y_q;
        whits_d = (whits_q == HIT_SAT) ? whits_q : whits_q + 20'd1;
      end

      // The eop pixel itself contributes, so latch from the updated values.
      if (sink_endofpacket) begin
        bhits_d  = whits_d;
        bvalid_d = (whits_d != 20'd0);
        if (whits_d != 20'd0) begin
          bx_min_d = wx_min_d;
          bx_max_d = wx_max_d;
          by_min_d = wy_min_d;
          by_max_d = wy_max_d;
        end else begin
          bx_min_d = '0;
          bx_max_d = '0;
          by_min_d = '0;
          by_max_d = '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      wx_min_q    <= '0;
      wx_max_q    <= '0;
      wy_min_q    <= '0;
      wy_max_q    <= '0;
      whits_q     <= '0;
      bvalid_q    <= 1'b0;
      bx_min_q    <= '0;
      bx_max_q    <= '0;
      by_min_q    <= '0;
      by_max_q    <= '0;
      bhits_q     <= '0;
    end else begin
      src_data_q  <= src_data_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wx_min_q    <= wx_min_d;
      wx_max_q    <= wx_max_d;
      wy_min_q    <= wy_min_d;
      wy_max_q    <= wy_max_d;
      whits_q     <= whits_d;
      bvalid_q    <= bvalid_d;
      bx_min_q    <= bx_min_d;
      bx_max_q    <= bx_max_d;
      by_min_q    <= by_min_d;
      by_max_q    <= by_max_d;
      bhits_q     <= bhits_d;
    end
  end

  assign source_data          = src_data_q;
  assign source_valid         = src_valid_q;
  assign source_startofpacket = src_sop_q;
  assign source_endofpacket   = src_eop_q;
  assign bbox_valid           = bvalid_q;
  assign bbox_x_min           = bx_min_q;
  assign bbox_x_max           = bx_max_q;
  assign bbox_y_min           = by_min_q;
  assign bbox_y_max           = by_max_q;
  assign hit_count            = bhits_q;

endmodule
